cpu_datapath: RTL

//   Accumulator datapath driven by the 32-bit microcode control word. Holds PC, MAR, MBR,
//   IR, BR and ACC and the ALU. Drives the single-port data memory. Returns IR and

---
 rtl/cpu_datapath.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cpu_datapath.sv
// Accumulator datapath (PC, MAR, MBR, IR, BR, ACC, ALU) steered by a 32-bit microcode word.
// Optional single-cycle unsigned divide on C16 when CPU_DATAPATH_DIV_EN is defined.
module cpu_datapath #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ctrl,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [15:0]       ir_out,
    output logic [3:0]        alu_flags,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q, mbr_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] br_q, br_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [3:0]        flags_q, flags_d;

    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res;
    logic                cf;
    logic                of;
    logic                acc_wr;

    always_comb begin
        mbr_d = mbr_q;
        if (ctrl[12])
            mbr_d = acc_q;
        else if (ctrl[3])
            mbr_d = mem_rdata;

        ir_d = ctrl[4] ? mbr_q : ir_q;

        mar_d = mar_q;
        if (ctrl[10])
            mar_d = pc_q;
        else if (ctrl[5])
            mar_d = mbr_q[ADDR_W-1:0];

        pc_d = pc_q;
        if (ctrl[14])
            pc_d = mbr_q[ADDR_W-1:0];
        else if (ctrl[6])
            pc_d = pc_q + 1'b1;

        br_d = ctrl[7] ? mbr_q : br_q;
    end

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, br_q};
        diff   = {1'b0, acc_q} - {1'b0, br_q};
        prod   = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, br_q};
        res    = acc_q;
        cf     = 1'b0;
        of     = 1'b0;
        acc_wr = 1'b1;
        if (ctrl[8]) begin
            res = '0;
        end else if (ctrl[9]) begin
            res = sum[DATA_W-1:0];
            cf  = sum[DATA_W];
            of  = (acc_q[DATA_W-1] == br_q[DATA_W-1]) && (sum[DATA_W-1] != acc_q[DATA_W-1]);
        end else if (ctrl[13]) begin
            res = diff[DATA_W-1:0];
            cf  = diff[DATA_W];
            of  = (acc_q[DATA_W-1] != br_q[DATA_W-1]) && (diff[DATA_W-1] != acc_q[DATA_W-1]);
        end else if (ctrl[15]) begin
            res = prod[DATA_W-1:0];
            of  = |prod[2*DATA_W-1:DATA_W];
`ifdef CPU_DATAPATH_DIV_EN
        end else if (ctrl[16]) begin
            // Divide by zero saturates to all-ones and raises OF
            if (br_q == '0) begin
                res = '1;
                of  = 1'b1;
            end else begin
                res = acc_q / br_q;
            end
`endif
        end else if (ctrl[17]) begin
            res = acc_q << br_q[4:0];
        end else if (ctrl[18]) begin
            res = acc_q >> br_q[4:0];
        end else if (ctrl[19]) begin
            res = acc_q & br_q;
        end else if (ctrl[20]) begin
            res = acc_q | br_q;
        end else if (ctrl[21]) begin
            res = ~br_q;
        end else begin
            acc_wr = 1'b0;
        end

        acc_d   = acc_wr ? res : acc_q;
        flags_d = acc_wr ? {res == '0, cf, of, res[DATA_W-1]} : flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= ADDR_W'(RESET_PC);
            mar_q   <= '0;
            mbr_q   <= '0;
            ir_q    <= '0;
            br_q    <= '0;
            acc_q   <= '0;
            flags_q <= '0;
        end else begin
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            mbr_q   <= mbr_d;
            ir_q    <= ir_d;
            br_q    <= br_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    // Gated by reset so an in-flight write is dropped the moment reset asserts
    assign mem_we    = ctrl[11] & rst_n;
    assign mem_addr  = mar_q;
    assign mem_wdata = mbr_q;
    assign ir_out    = ir_q;
    assign alu_flags = flags_q;
    assign acc_out   = acc_q;
    assign pc_out    = pc_q;

    logic unused_ctrl;
`ifdef CPU_DATAPATH_DIV_EN
    assign unused_ctrl = ^{ctrl[31:22], ctrl[2:0]};
`else
    assign unused_ctrl = ^{ctrl[31:22], ctrl[16], ctrl[2:0]};
`endif

endmodule
